// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single-outstanding memory port.
// Round-robin tie-break, registered responses, sticky timeout error.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_done,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  err
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_lsu_q, last_lsu_d;
    logic                owner_lsu_q, owner_lsu_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                mem_ren_q, mem_ren_d;
    logic                mem_wen_q, mem_wen_d;
    logic                ifu_resp_q, ifu_resp_d;
    logic                lsu_resp_q, lsu_resp_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic                grant_lsu;
    logic                resp_now;
    logic [DATA_W-1:0]   resp_data;

    // Next-state, grant and response logic; ready is a same-cycle handshake.
    always_comb begin
        state_d       = state_q;
        last_lsu_d    = last_lsu_q;
        owner_lsu_d   = owner_lsu_q;
        wen_d         = wen_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        mem_ren_d     = 1'b0;
        mem_wen_d     = 1'b0;
        ifu_resp_d    = 1'b0;
        lsu_resp_d    = 1'b0;
        ifu_rdata_d   = ifu_rdata_q;
        lsu_rdata_d   = lsu_rdata_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        grant_lsu     = 1'b0;
        resp_now      = 1'b0;
        resp_data     = '0;

        case (state_q)
            S_IDLE: begin
                if (ifu_req_valid || lsu_req_valid) begin
                    // LSU wins a tie only when IFU was granted last.
                    grant_lsu     = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
                    lsu_req_ready = grant_lsu;
                    ifu_req_ready = !grant_lsu;
                    last_lsu_d    = grant_lsu;
                    owner_lsu_d   = grant_lsu;
                    wen_d         = grant_lsu && lsu_wen;
                    addr_d        = grant_lsu ? lsu_addr  : ifu_addr;
                    wdata_d       = grant_lsu ? lsu_wdata : '0;
                    wmask_d       = grant_lsu ? lsu_wmask : '0;
                    mem_wen_d     = grant_lsu && lsu_wen;
                    mem_ren_d     = !(grant_lsu && lsu_wen);
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_done) begin
                    resp_now  = 1'b1;
                    resp_data = wen_q ? '0 : mem_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    resp_now  = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (resp_now) begin
                    state_d    = S_IDLE;
                    ifu_resp_d = !owner_lsu_q;
                    lsu_resp_d = owner_lsu_q;
                    if (owner_lsu_q) begin
                        lsu_rdata_d = resp_data;
                    end else begin
                        ifu_rdata_d = resp_data;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_lsu_q  <= 1'b0;
            owner_lsu_q <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            owner_lsu_q <= owner_lsu_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            ifu_resp_q  <= ifu_resp_d;
            lsu_resp_q  <= lsu_resp_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign ifu_resp_valid = ifu_resp_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_resp_valid = lsu_resp_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign mem_ren        = mem_ren_q;
    assign mem_wen        = mem_wen_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign err            = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-requester vector table plus tie, timeout,
// mid-transaction reset and stray-completion sequences.
module tb_mem_arbiter;
    localparam int unsigned TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_ren, mem_wen, mem_done, err;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_vec = 0;
    int n_bad = 0;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_done(mem_done), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        int          dly;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    // Advance to just after the next rising edge; inputs change only here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From the ISSUE cycle: wait dly WAIT cycles, then complete; returns in the response cycle.
    task automatic serve(input logic [63:0] rd, input int dly, input logic [63:0] addr);
        step();
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk1("wait_no_resp", ifu_resp_valid | lsu_resp_valid, 1'b0);
            chk1("wait_no_strobe", mem_ren | mem_wen, 1'b0);
            chk("wait_addr_hold", mem_addr, addr);
            step();
        end
        mem_done  = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        chk1("done_cycle_no_resp", ifu_resp_valid | lsu_resp_valid, 1'b0);
        step();
        mem_done  = 1'b0;
        mem_rdata = 64'hFFFF_0000_DEAD_0000;
    endtask

    // One single-requester transaction, start to finish.
    task automatic run_vec(input vec_t v);
        logic is_lsu, st;
        logic [63:0] exp_rd;
        is_lsu = v.lsu_v;
        st     = v.lsu_v && v.wen;
        exp_rd = st ? 64'h0 : v.rdata;
        ifu_req_valid = v.ifu_v;
        lsu_req_valid = v.lsu_v;
        ifu_addr  = v.addr;
        lsu_addr  = v.addr;
        lsu_wen   = v.wen;
        lsu_wdata = v.wdata;
        lsu_wmask = v.wmask;
        @(negedge clk);
        chk1("ifu_ready", ifu_req_ready, !is_lsu);
        chk1("lsu_ready", lsu_req_ready, is_lsu);
        step();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        @(negedge clk);
        chk1("issue_ren", mem_ren, !st);
        chk1("issue_wen", mem_wen, st);
        chk("issue_addr", mem_addr, v.addr);
        chk("issue_wmask", 64'(mem_wmask), is_lsu ? 64'(v.wmask) : 64'h0);
        if (st) chk("issue_wdata", mem_wdata, v.wdata);
        chk1("issue_busy_ready", ifu_req_ready | lsu_req_ready, 1'b0);
        serve(v.rdata, v.dly, v.addr);
        @(negedge clk);
        chk1("resp_owner", is_lsu ? lsu_resp_valid : ifu_resp_valid, 1'b1);
        chk1("resp_other", is_lsu ? ifu_resp_valid : lsu_resp_valid, 1'b0);
        chk("resp_rdata", is_lsu ? lsu_rdata : ifu_rdata, exp_rd);
        step();
        @(negedge clk);
        chk1("resp_pulse_end", ifu_resp_valid | lsu_resp_valid, 1'b0);
        chk("rdata_hold", is_lsu ? lsu_rdata : ifu_rdata, exp_rd);
        step();
    endtask

    vec_t tbl [6];
    logic [63:0] held;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 64'h8000_0000, 64'h0, 8'hFF, 64'h0000_0413_0000_0297, 1};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 64'h8000_1008, 64'hDEAD_BEEF, 8'h0F, 64'h1111_2222_3333_4444, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 64'h8000_1010, 64'h0, 8'hFF, 64'hCAFE_F00D_1234_5678, 3};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 64'h8000_0004, 64'h0, 8'h00, 64'hA5A5_A5A5_5A5A_5A5A, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 64'h8000_0008, 64'h77, 8'hF0, 64'h0123_4567_89AB_CDEF, 2};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 64'h8000_2000, 64'h0, 8'hFF, 64'h5555_AAAA_5555_AAAA, 1};

        rst = 1'b1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        mem_done = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("rst_err", err, 1'b0);
        chk1("rst_resp", ifu_resp_valid | lsu_resp_valid, 1'b0);
        chk1("rst_strobes", mem_ren | mem_wen, 1'b0);
        chk("rst_ifu_rdata", ifu_rdata, 64'h0);
        chk("rst_lsu_rdata", lsu_rdata, 64'h0);
        step();

        // Ties right after reset: LSU first, then alternate; losers wait.
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0040;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_1040; lsu_wmask = 8'hFF;
        @(negedge clk);
        chk1("tie1_lsu_ready", lsu_req_ready, 1'b1);
        chk1("tie1_ifu_ready", ifu_req_ready, 1'b0);
        step();
        lsu_req_valid = 1'b0;
        @(negedge clk);
        chk1("tie1_busy_ifu_ready", ifu_req_ready, 1'b0);
        chk("tie1_addr", mem_addr, 64'h8000_1040);
        serve(64'h1111_0000_0000_0001, 0, 64'h8000_1040);
        lsu_req_valid = 1'b1;
        @(negedge clk);
        chk1("tie1_lsu_resp", lsu_resp_valid, 1'b1);
        chk("tie1_lsu_rdata", lsu_rdata, 64'h1111_0000_0000_0001);
        chk1("tie2_ifu_ready", ifu_req_ready, 1'b1);
        chk1("tie2_lsu_ready", lsu_req_ready, 1'b0);
        step();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("tie2_addr", mem_addr, 64'h8000_0040);
        chk1("tie2_ren", mem_ren, 1'b1);
        serve(64'h2222_0000_0000_0002, 1, 64'h8000_0040);
        ifu_req_valid = 1'b1;
        @(negedge clk);
        chk1("tie2_ifu_resp", ifu_resp_valid, 1'b1);
        chk("tie2_ifu_rdata", ifu_rdata, 64'h2222_0000_0000_0002);
        chk1("tie3_lsu_ready", lsu_req_ready, 1'b1);
        chk1("tie3_ifu_ready", ifu_req_ready, 1'b0);
        step();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clk);
        chk("tie3_addr", mem_addr, 64'h8000_1040);
        serve(64'h3333_0000_0000_0003, 0, 64'h8000_1040);
        @(negedge clk);
        chk("tie3_lsu_rdata", lsu_rdata, 64'h3333_0000_0000_0003);
        step();

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Timeout on an LSU load: err, zero data, then normal service resumes.
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_3000;
        @(negedge clk);
        chk1("to_lsu_ready", lsu_req_ready, 1'b1);
        step();
        lsu_req_valid = 1'b0;
        step();
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            if (i == 0 || i == int'(TIMEOUT) - 1) begin
                @(negedge clk);
                chk1("to_wait_resp", lsu_resp_valid, 1'b0);
                chk1("to_wait_err", err, 1'b0);
            end
            step();
        end
        @(negedge clk);
        chk1("to_resp", lsu_resp_valid, 1'b1);
        chk("to_rdata", lsu_rdata, 64'h0);
        chk1("to_err", err, 1'b1);
        chk1("to_ifu_resp", ifu_resp_valid, 1'b0);
        step();
        run_vec('{1'b1, 1'b0, 1'b0, 64'h8000_0100, 64'h0, 8'h00, 64'h0BAD_F00D_0000_0001, 0});
        @(negedge clk);
        chk1("err_sticky", err, 1'b1);
        step();

        // Reset during WAIT, then a stray completion.
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0200;
        @(negedge clk);
        chk1("rw_ifu_ready", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_done = 1'b1; mem_rdata = 64'h9999_8888_7777_6666;
        @(negedge clk);
        chk1("rw_err_clear", err, 1'b0);
        chk("rw_ifu_rdata", ifu_rdata, 64'h0);
        step();
        mem_done = 1'b0;
        @(negedge clk);
        chk1("rw_no_resp", ifu_resp_valid | lsu_resp_valid, 1'b0);
        chk1("rw_no_strobe", mem_ren | mem_wen, 1'b0);
        step();
        run_vec('{1'b0, 1'b1, 1'b0, 64'h8000_4000, 64'h0, 8'h3C, 64'h4444_3333_2222_1111, 0});

        // Completion pulse in IDLE with nothing pending changes nothing.
        held = lsu_rdata;
        mem_done = 1'b1; mem_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
        step();
        mem_done = 1'b0;
        @(negedge clk);
        chk1("idle_done_resp", ifu_resp_valid | lsu_resp_valid, 1'b0);
        chk1("idle_done_strobe", mem_ren | mem_wen, 1'b0);
        chk("idle_done_lsu_rdata", lsu_rdata, held);
        chk("idle_done_ifu_rdata", ifu_rdata, 64'h0);
        chk1("idle_done_err", err, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 64, request address width.
REQ-002 SHALL have parameter DATA_W, 64, data width; byte mask is DATA_W/8 bits.
REQ-003 SHALL have parameter TIMEOUT, 255, max cycles waiting for mem_done before error.
REQ-004 SHALL have clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ifu_req_valid  input  1  fetch read request.
REQ-007 SHALL have ifu_req_ready  output  1  fetch request accepted this cycle.
REQ-008 SHALL have ifu_addr  input  ADDR_W  fetch address.
REQ-009 SHALL have ifu_resp_valid  output  1  one-cycle pulse, ifu_rdata valid.
REQ-010 SHALL have ifu_rdata  output  DATA_W  fetch read data.
REQ-011 SHALL have lsu_req_valid, lsu_req_ready  input/output  1 each  load/store request handshake.
REQ-012 SHALL have lsu_wen  input  1  1 = store, 0 = load.
REQ-013 SHALL have lsu_addr  input  ADDR_W; lsu_wdata  input  DATA_W; lsu_wmask  input  DATA_W/8.
REQ-014 SHALL have lsu_resp_valid  output  1; lsu_rdata  output  DATA_W  load data, or zero for stores.
REQ-015 SHALL have mem_ren, mem_wen  output  1 each  one-cycle strobes to the memory port.
REQ-016 SHALL have mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_wmask  output  DATA_W/8.
REQ-017 SHALL have mem_done  input  1  memory completion pulse; mem_rdata  input  DATA_W  valid with mem_done.
REQ-018 SHALL have err  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, with exactly one outstanding memory transaction.
REQ-020 In IDLE with any request valid, SHALL grant one requester: assert its req_ready for that cycle, latch addr/wdata/wmask/wen/owner, and go to ISSUE.
REQ-021 Tie-break SHALL be round-robin: on simultaneous valid, grant the requester not granted last; last_grant resets to IFU, so LSU wins the first tie.
REQ-022 A single valid requester SHALL be granted regardless of last_grant.
REQ-023 IFU grants SHALL force a read: mem_wen=0, mem_wmask=0.
REQ-024 In ISSUE, SHALL drive mem_ren (load or fetch) or mem_wen (store) high for exactly one cycle with latched fields, then go to WAIT.
REQ-025 mem_addr/mem_wdata/mem_wmask SHALL hold the latched values from ISSUE until leaving WAIT.
REQ-026 In WAIT, on mem_done, SHALL pulse the owner's resp_valid the next cycle with rdata = registered mem_rdata, then return to IDLE.
REQ-027 Minimum latency from grant to resp_valid SHALL be 3 cycles: grant, ISSUE, WAIT with mem_done=1.
REQ-028 req_ready SHALL be 0 for both requesters outside IDLE; a request arriving while busy waits and is not lost.
REQ-029 A non-owner's resp_valid SHALL never assert; rdata outputs SHALL hold their last value between responses.
REQ-030 mem_done outside WAIT SHALL be ignored.
REQ-031 The WAIT counter SHALL start at 0 on entry; at TIMEOUT cycles without mem_done, SHALL set err, pulse owner resp_valid with rdata = 0, and return to IDLE.
REQ-032 err SHALL remain set until rst.
REQ-033 Round-robin update SHALL occur only on grant.

Reset
REQ-034 While rst=1 at a posedge, SHALL enter IDLE, clear last_grant to IFU, the WAIT counter, err, all ready/resp_valid/mem strobes, and rdata outputs to 0.
REQ-035 rst asserted mid-transaction (ISSUE or WAIT) SHALL abort it with no response pulse; a later mem_done SHALL be ignored.

Verification
REQ-036 IFU only, addr 0x80000000, mem_done 2 cycles after mem_ren, mem_rdata 0x00000413_00000297 -> one mem_ren pulse at 0x80000000; ifu_resp_valid with that data; lsu_resp_valid stays 0.
REQ-037 IFU and LSU (load) valid in the same cycle after reset -> LSU granted first, IFU next; back-to-back ties alternate.
REQ-038 LSU store addr 0x80001008, wdata 0xDEADBEEF, wmask 0x0F -> one mem_wen pulse with those values, mem_ren=0; lsu_resp_valid with lsu_rdata=0.
REQ-039 mem_done held 0 for TIMEOUT cycles -> err=1, owner resp_valid with rdata=0, FSM IDLE; next request still serviced.
REQ-040 rst pulsed during WAIT, then stray mem_done -> no resp_valid, err=0, FSM IDLE.
REQ-041 mem_done pulsed in IDLE with no requests -> no outputs change.
